// File: rtl/duck_gfx_pkg.sv
// Shared types and constants for the duck sprite graphics path.
package duck_gfx_pkg;

    typedef logic [3:0]  pal_idx_t;
    typedef logic [9:0]  coord_t;
    typedef logic [23:0] rgb_t;

    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;
    localparam int DUCK_SPR_W      = 32;
    localparam int DUCK_SPR_H      = 32;
    localparam int DUCK_NUM_FRAMES = 3;
    localparam int DUCK_FRAME_DIV  = 8;

    localparam pal_idx_t TRANSPARENT_IDX = 4'd0;
    localparam pal_idx_t BG_IDX          = 4'd1;

    // DrawX/DrawY to pal_read_address, in clock edges
    localparam int PIPE_LAT = 3;

endpackage

// File: rtl/duck_anim_counter.sv
// Flap-animation divider and frame-synchronous shadow copy of the sprite state.
// Everything here changes only on an edge where frame_start is high, so the
// pixel pipeline sees one consistent position/frame for a whole video frame.
module duck_anim_counter
    import duck_gfx_pkg::*;
#(
    parameter int NUM_FRAMES = DUCK_NUM_FRAMES,
    parameter int FRAME_DIV  = DUCK_FRAME_DIV
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  coord_t     spr_x,
    input  coord_t     spr_y,
    input  logic       spr_en,
    input  logic       spr_flip,
    output coord_t     sx,
    output coord_t     sy,
    output logic       en,
    output logic       flip,
    output logic [1:0] anim_frame
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;

    // Latch sprite state and step the animation once per video frame
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx         <= '0;
            sy         <= '0;
            en         <= 1'b0;
            flip       <= 1'b0;
            div_cnt    <= '0;
            anim_frame <= 2'd0;
        end else if (frame_start) begin
            sx   <= spr_x;
            sy   <= spr_y;
            en   <= spr_en;
            flip <= spr_flip;
            if (div_cnt == DIV_W'(FRAME_DIV - 1)) begin
                div_cnt    <= '0;
                anim_frame <= (anim_frame == 2'(NUM_FRAMES - 1)) ? 2'd0 : anim_frame + 2'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/duck_sprite_index_pipe.sv
// Per-pixel sprite fetch: DrawX/DrawY -> sprite ROM address -> palette index.
// Stream protocol: pal_valid qualifies pal_read_address on the same cycle;
// there is no ready, the pipe advances every clock and pix_valid-low cycles
// travel through as bubbles (pal_valid=0, pal_read_address=0).
module duck_sprite_index_pipe
    import duck_gfx_pkg::*;
#(
    parameter int       SPR_W           = DUCK_SPR_W,
    parameter int       SPR_H           = DUCK_SPR_H,
    parameter int       NUM_FRAMES      = DUCK_NUM_FRAMES,
    parameter int       FRAME_DIV       = DUCK_FRAME_DIV,
    parameter pal_idx_t TRANSPARENT_IDX = duck_gfx_pkg::TRANSPARENT_IDX,
    parameter pal_idx_t BG_IDX          = duck_gfx_pkg::BG_IDX
) (
    input  logic        Clk,
    input  logic        Reset,
    input  coord_t      DrawX,
    input  coord_t      DrawY,
    input  logic        pix_valid,
    input  logic        frame_start,
    input  coord_t      spr_x,
    input  coord_t      spr_y,
    input  logic        spr_en,
    input  logic        spr_flip,
    output logic [11:0] spr_rom_addr,
    input  pal_idx_t    spr_rom_data,
    output pal_idx_t    pal_read_address,
    output logic        pal_valid,
    output logic [1:0]  anim_frame
);

    coord_t sx, sy;
    logic   en, flip;

    duck_anim_counter #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_DIV  (FRAME_DIV)
    ) u_anim (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_en      (spr_en),
        .spr_flip    (spr_flip),
        .sx          (sx),
        .sy          (sy),
        .en          (en),
        .flip        (flip),
        .anim_frame  (anim_frame)
    );

    // 11-bit coordinates so a sprite hanging off the right/bottom edge never wraps
    logic [10:0] dx11, dy11, sx11, sy11, x_end, y_end, col, row, colm;
    logic        hit_c;
    logic [11:0] addr_c;

    assign dx11  = {1'b0, DrawX};
    assign dy11  = {1'b0, DrawY};
    assign sx11  = {1'b0, sx};
    assign sy11  = {1'b0, sy};
    assign x_end = sx11 + 11'(SPR_W);
    assign y_end = sy11 + 11'(SPR_H);
    assign col   = dx11 - sx11;
    assign row   = dy11 - sy11;
    assign colm  = flip ? (11'(SPR_W - 1) - col) : col;

    // Stage 0 hit test and address arithmetic
    always_comb begin
        hit_c  = pix_valid & en & (dx11 >= sx11) & (dx11 < x_end)
                                & (dy11 >= sy11) & (dy11 < y_end);
        addr_c = 12'(32'(anim_frame) * SPR_W * SPR_H)
               + 12'(32'(row) * SPR_W)
               + 12'(colm);
    end

    logic s0_hit, s0_pv, s1_hit, s1_pv;

    // Three-stage pipe: ROM address, wait for ROM data, resolve palette index
    always_ff @(posedge Clk) begin
        if (Reset) begin
            spr_rom_addr     <= '0;
            s0_hit           <= 1'b0;
            s0_pv            <= 1'b0;
            s1_hit           <= 1'b0;
            s1_pv            <= 1'b0;
            pal_valid        <= 1'b0;
            pal_read_address <= '0;
        end else begin
            spr_rom_addr <= hit_c ? addr_c : 12'd0;
            s0_hit       <= hit_c;
            s0_pv        <= pix_valid;
            s1_hit       <= s0_hit;
            s1_pv        <= s0_pv;
            pal_valid    <= s1_pv;
            if (!s1_pv)
                pal_read_address <= '0;
            else if (!s1_hit || spr_rom_data == TRANSPARENT_IDX)
                pal_read_address <= BG_IDX;
            else
                pal_read_address <= spr_rom_data;
        end
    end

endmodule

// File: tb/tb_duck_sprite_index_pipe.sv
// Directed bench for duck_sprite_index_pipe with a synchronous sprite ROM model.
module tb_duck_sprite_index_pipe;
    import duck_gfx_pkg::*;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset = 1'b1;
    coord_t      DrawX = '0, DrawY = '0;
    logic        pix_valid = 1'b0, frame_start = 1'b0;
    coord_t      spr_x = '0, spr_y = '0;
    logic        spr_en = 1'b0, spr_flip = 1'b0;
    logic [11:0] spr_rom_addr;
    pal_idx_t    spr_rom_data;
    pal_idx_t    pal_read_address;
    logic        pal_valid;
    logic [1:0]  anim_frame;

    duck_sprite_index_pipe dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .DrawX            (DrawX),
        .DrawY            (DrawY),
        .pix_valid        (pix_valid),
        .frame_start      (frame_start),
        .spr_x            (spr_x),
        .spr_y            (spr_y),
        .spr_en           (spr_en),
        .spr_flip         (spr_flip),
        .spr_rom_addr     (spr_rom_addr),
        .spr_rom_data     (spr_rom_data),
        .pal_read_address (pal_read_address),
        .pal_valid        (pal_valid),
        .anim_frame       (anim_frame)
    );

    // Sprite ROM: 1-cycle synchronous read
    logic [3:0] rom_mem [0:4095];
    always @(posedge Clk) spr_rom_data <= rom_mem[spr_rom_addr];

    // ---------------- scoreboard ----------------
    logic [13:0] exp_a_q[$];   // {anim_frame, spr_rom_addr} one edge after drive
    logic [4:0]  exp_p_q[$];   // {pal_valid, pal_read_address} three edges after drive
    int n_vec = 0;
    int n_err = 0;
    int m_div = 0;
    int m_anim = 0;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic fs, input logic pv,
                         input logic [9:0] dx, input logic [9:0] dy,
                         input logic [11:0] e_addr, input logic [3:0] e_pal);
        @(negedge Clk);
        Reset       = rst;
        frame_start = fs;
        pix_valid   = pv;
        DrawX       = dx;
        DrawY       = dy;
        if (rst) begin
            m_div  = 0;
            m_anim = 0;
            exp_p_q.delete();
            repeat (3) exp_p_q.push_back(5'd0);
        end else begin
            if (fs) begin
                if (m_div == 7) begin
                    m_div  = 0;
                    m_anim = (m_anim == 2) ? 0 : m_anim + 1;
                end else begin
                    m_div = m_div + 1;
                end
            end
            exp_p_q.push_back({pv, pv ? e_pal : 4'd0});
        end
        exp_a_q.push_back({2'(m_anim), rst ? 12'd0 : e_addr});
    endtask

    task automatic pix(input logic [9:0] dx, input logic [9:0] dy,
                       input logic [11:0] e_addr, input logic [3:0] e_pal);
        drive(1'b0, 1'b0, 1'b1, dx, dy, e_addr, e_pal);
    endtask

    task automatic fs_pulse();
        drive(1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 12'd0, 4'd0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0, 4'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [13:0] ea;
        logic [4:0]  ep;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_a_q.size() > 0) begin
                ea = exp_a_q.pop_front();
                n_vec++;
                if (spr_rom_addr !== ea[11:0]) begin
                    n_err++;
                    $display("FAIL spr_rom_addr @%0t: got %0d want %0d", $time, spr_rom_addr, ea[11:0]);
                end
                n_vec++;
                if (anim_frame !== ea[13:12]) begin
                    n_err++;
                    $display("FAIL anim_frame @%0t: got %0d want %0d", $time, anim_frame, ea[13:12]);
                end
            end
            if (exp_p_q.size() > 0) begin
                ep = exp_p_q.pop_front();
                n_vec++;
                if ({pal_valid, pal_read_address} !== ep) begin
                    n_err++;
                    $display("FAIL pal_out @%0t: got valid=%0b idx=%0d want valid=%0b idx=%0d",
                             $time, pal_valid, pal_read_address, ep[4], ep[3:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int a = 0; a < 4096; a++) rom_mem[a] = 4'hE;
        rom_mem[67]   = 4'd5;
        rom_mem[92]   = 4'd9;
        rom_mem[96]   = 4'd0;    // transparent texel
        rom_mem[1116] = 4'd12;

        drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0, 4'd0);

        // basic hit
        spr_x = 10'd100; spr_y = 10'd50; spr_en = 1'b1; spr_flip = 1'b0;
        fs_pulse();                                   // fs #1
        pix(10'd103, 10'd52, 12'd67, 4'd5);

        // horizontal / vertical boundaries
        pix(10'd99,  10'd52, 12'd0,   4'd1);
        pix(10'd131, 10'd52, 12'd95,  4'hE);
        pix(10'd132, 10'd52, 12'd0,   4'd1);
        pix(10'd103, 10'd49, 12'd0,   4'd1);
        pix(10'd103, 10'd81, 12'd995, 4'hE);
        pix(10'd103, 10'd82, 12'd0,   4'd1);

        // transparent texel and bubble
        pix(10'd100, 10'd53, 12'd96, 4'd1);
        drive(1'b0, 1'b0, 1'b0, 10'd103, 10'd52, 12'd0, 4'd0);

        // mid-frame position change is ignored until the next frame_start
        spr_x = 10'd200;
        pix(10'd103, 10'd52, 12'd67, 4'd5);
        pix(10'd203, 10'd52, 12'd0,  4'd1);
        fs_pulse();                                   // fs #2
        pix(10'd203, 10'd52, 12'd67, 4'd5);
        pix(10'd103, 10'd52, 12'd0,  4'd1);

        // horizontal flip
        spr_x = 10'd100; spr_flip = 1'b1;
        fs_pulse();                                   // fs #3
        pix(10'd103, 10'd52, 12'd92, 4'd9);

        // animation step after 8 frame_starts
        repeat (5) fs_pulse();                        // fs #4..#8
        pix(10'd103, 10'd52, 12'd1116, 4'd12);

        // right-edge clipping without wrap
        spr_x = 10'd620; spr_flip = 1'b0;
        fs_pulse();                                   // fs #9
        pix(10'd639, 10'd52, 12'd1107, 4'hE);
        pix(10'd5,   10'd52, 12'd0,    4'd1);

        // animation wraps 1 -> 2 -> 0
        repeat (16) fs_pulse();                       // fs #10..#25
        pix(10'd639, 10'd52, 12'd83, 4'hE);

        // reset coincident with frame_start mid-stream
        pix(10'd639, 10'd52, 12'd83, 4'hE);
        drive(1'b1, 1'b1, 1'b1, 10'd639, 10'd52, 12'd0, 4'd0);
        pix(10'd639, 10'd52, 12'd0, 4'd1);
        pix(10'd639, 10'd52, 12'd0, 4'd1);
        pix(10'd639, 10'd52, 12'd0, 4'd1);

        // recovery
        spr_x = 10'd100; spr_y = 10'd50; spr_en = 1'b1; spr_flip = 1'b0;
        fs_pulse();
        pix(10'd103, 10'd52, 12'd67, 4'd5);
        idle();
        idle();

        repeat (4) @(posedge Clk);
        #2;
        n_vec++;
        if (exp_a_q.size() != 0 || exp_p_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d entries left want 0/0", exp_a_q.size(), exp_p_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
